// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Packs a 32-bit word stream into 512-bit SHA-256 message blocks and adds
//   the padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length.
//   Each finished block is offered with a valid/ack handshake. Depending on
//   where the marker falls, a message ends with one or two padding blocks.
//
//   Optional build macro: SHA256_PADDER_BYTESWAP_EN. When it is defined,
//   data_in is byte-reversed before packing, for little-endian producers.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   data_in[31:0]            message word; first byte in [31:24]
//   data_valid/data_ready    input handshake
//   data_last                last word of the message (qualified by data_valid)
//   data_bytes[1:0]          valid bytes in the last word (0 means 4)
//   block_out[511:0]         block; word 0 in [511:480]
//   block_valid/block_ack    output handshake
//   block_first/block_final  message start/end flags; valid with block_valid
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [31:0]  data_in,
  input  logic         data_valid,
  input  logic         data_last,
  input  logic [1:0]   data_bytes,
  output logic         data_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ack,
  output logic         block_first,
  output logic         block_final
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_LEN, S_HOLD} state_t;

  state_t             state, state_nx;
  logic [0:15][31:0]  blk;         // blk[0] is the word at the top of block_out
  logic [3:0]         idx;
  logic [LEN_W-1:0]   len;
  logic [3:0]         last_k;      // slot of the last message word
  logic [1:0]         last_b;      // bytes in that word, 0 means 4
  logic               final_r;
  logic               need_len;    // the length goes in an additional block
  logic               marker_w0;   // that block starts with the marker
  logic               first_pend;  // the next block starts a message

  logic [31:0]        word_in, word_msk, byte_mask, marker;
  logic [2:0]         nbytes;
  logic [4:0]         pad_p;       // marker word index, 16 means next block
  logic [63:0]        len64;

`ifdef SHA256_PADDER_BYTESWAP_EN
  assign word_in = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
`else
  assign word_in = data_in;
`endif

  always_comb begin
    nbytes = 3'd4;
    if (data_last && data_bytes != 2'd0) nbytes = {1'b0, data_bytes};
    case (nbytes)
      3'd1:    byte_mask = 32'hFF00_0000;
      3'd2:    byte_mask = 32'hFFFF_0000;
      3'd3:    byte_mask = 32'hFFFF_FF00;
      default: byte_mask = 32'hFFFF_FFFF;
    endcase
    word_msk = word_in & byte_mask;
  end

  // Partial last word: marker goes into the first unused byte of that word.
  // Full last word: marker is a whole word in the next slot.
  assign pad_p  = (last_b == 2'd0) ? ({1'b0, last_k} + 5'd1) : {1'b0, last_k};
  assign marker = 32'h0000_0080 << {(2'd3 - last_b), 3'b000};
  assign len64  = 64'(len);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_FILL;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    data_ready  = 1'b0;
    block_valid = 1'b0;
    case (state)
      S_FILL: begin
        data_ready = 1'b1;
        if (data_valid) begin
          if (data_last)          state_nx = S_PAD;
          else if (idx == 4'd15)  state_nx = S_HOLD;
        end
      end
      S_PAD:   state_nx = (pad_p <= 5'd13) ? S_LEN : S_HOLD;
      S_LEN:   state_nx = S_HOLD;
      S_HOLD: begin
        block_valid = 1'b1;
        if (block_ack) state_nx = need_len ? S_LEN : S_FILL;
      end
      default: state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blk        <= '0;
      idx        <= '0;
      len        <= '0;
      last_k     <= '0;
      last_b     <= '0;
      final_r    <= 1'b0;
      need_len   <= 1'b0;
      marker_w0  <= 1'b0;
      first_pend <= 1'b1;
    end else begin
      case (state)
        S_FILL: if (data_valid) begin
          blk[idx] <= word_msk;
          len      <= len + LEN_W'({nbytes, 3'b000});
          idx      <= (data_last || idx == 4'd15) ? 4'd0 : idx + 4'd1;
          final_r  <= 1'b0;
          if (data_last) begin
            last_k <= idx;
            last_b <= data_bytes;
          end
        end
        S_PAD: begin
          if (last_b != 2'd0)  blk[last_k]     <= blk[last_k] | marker;
          else if (!pad_p[4])  blk[pad_p[3:0]] <= 32'h8000_0000;
          // Slots past the marker still hold the previous message's words.
          for (int i = 0; i < 16; i++)
            if (5'(i) > pad_p) blk[i] <= 32'h0;
          if (pad_p > 5'd13) begin
            need_len  <= 1'b1;
            marker_w0 <= pad_p[4];
          end
        end
        S_LEN: begin
          blk[14] <= len64[63:32];
          blk[15] <= len64[31:0];
          final_r <= 1'b1;
        end
        S_HOLD: if (block_ack) begin
          first_pend <= 1'b0;
          if (need_len) begin
            blk <= '0;
            if (marker_w0) blk[0] <= 32'h8000_0000;
            need_len <= 1'b0;
          end else if (final_r) begin
            first_pend <= 1'b1;
            len        <= '0;
            final_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign block_out   = blk;
  assign block_first = block_valid & first_pend;
  assign block_final = block_valid & final_r;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed blocks for short,
// two-block, multi-block and reset-abort messages, plus handshake timing.
module tb_sha256_msg_padder;

  logic         CLK = 1'b0;
  logic         RST;
  logic [31:0]  data_in;
  logic         data_valid, data_last, data_ready;
  logic [1:0]   data_bytes;
  logic [511:0] block_out;
  logic         block_valid, block_ack, block_first, block_final;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sha256_msg_padder dut (
    .CLK(CLK), .RST(RST),
    .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
    .data_bytes(data_bytes), .data_ready(data_ready),
    .block_out(block_out), .block_valid(block_valid), .block_ack(block_ack),
    .block_first(block_first), .block_final(block_final)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus is written big-endian; present it in the producer's byte order.
  function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SHA256_PADDER_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] dw(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // All tasks start and end on a falling edge.
  task automatic send(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int n = 0;
    while (!data_ready && n < 50) begin @(negedge CLK); n++; end
    if (!data_ready) chk("send_timeout", {511'd0, data_ready}, 512'd1);
    data_in = sw(d); data_valid = 1'b1; data_last = last; data_bytes = nb;
    @(posedge CLK); @(negedge CLK);
    data_valid = 1'b0; data_last = 1'b0; data_bytes = 2'd0; data_in = '0;
  endtask

  task automatic wait_blk(input string tag);
    int n = 0;
    while (!block_valid && n < 50) begin @(negedge CLK); n++; end
    chk(tag, {511'd0, block_valid}, 512'd1);
  endtask

  task automatic ack;
    block_ack = 1'b1;
    @(posedge CLK); @(negedge CLK);
    block_ack = 1'b0;
  endtask

  task automatic run_abc(input string tag);
    logic [0:15][31:0] e;
    e = '0; e[0] = 32'h6162_6380; e[15] = 32'h0000_0018;
    send(32'h6162_6300, 1'b1, 2'd3);
    chk({tag, "_lat0"}, {511'd0, block_valid}, 512'd0);
    @(negedge CLK);
    chk({tag, "_lat1"}, {511'd0, block_valid}, 512'd0);
    @(negedge CLK);
    chk({tag, "_lat2"}, {511'd0, block_valid}, 512'd1);
    chk({tag, "_blk"}, block_out, e);
    chk({tag, "_flags"}, {510'd0, block_first, block_final}, 512'd3);
    // ack in the first valid cycle: valid lasts exactly one cycle
    ack;
    chk({tag, "_1cyc"}, {511'd0, block_valid}, 512'd0);
    chk({tag, "_rdy"}, {511'd0, data_ready}, 512'd1);
  endtask

  initial begin
    logic [0:15][31:0] e;
    logic [511:0]      snap;
    logic [1:0]        fsnap;
    logic              stable;

    RST = 1'b0; data_in = '0; data_valid = 1'b0; data_last = 1'b0;
    data_bytes = 2'd0; block_ack = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_out", block_out, 512'd0);
    chk("rst_flags", {509'd0, block_valid, block_first, block_final}, 512'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_ready", {511'd0, data_ready}, 512'd1);

    // single-block message
    run_abc("abc");

    // 14 full words: marker at word 14, length in an additional block
    for (int i = 0; i < 14; i++) send(dw(i), i == 13, 2'd0);
    wait_blk("w14_a_wait");
    e = '0;
    for (int i = 0; i < 14; i++) e[i] = dw(i);
    e[14] = 32'h8000_0000;
    chk("w14_a_blk", block_out, e);
    chk("w14_a_flags", {510'd0, block_first, block_final}, 512'd2);
    // hold without ack: everything stays put and no input is taken
    snap = block_out; fsnap = {block_first, block_final}; stable = 1'b1;
    data_valid = 1'b1; data_in = 32'hDEAD_BEEF;
    repeat (10) begin
      @(negedge CLK);
      if (block_out !== snap || {block_first, block_final} !== fsnap ||
          block_valid !== 1'b1 || data_ready !== 1'b0) stable = 1'b0;
    end
    data_valid = 1'b0; data_in = '0;
    chk("w14_hold", {511'd0, stable}, 512'd1);
    ack;
    wait_blk("w14_b_wait");
    e = '0; e[15] = 32'h0000_01C0;
    chk("w14_b_blk", block_out, e);
    chk("w14_b_flags", {510'd0, block_first, block_final}, 512'd1);
    ack;

    // 16 full words, last on word 15: marker opens the additional block
    for (int i = 0; i < 16; i++) send(dw(i + 32), i == 15, 2'd0);
    wait_blk("w16_a_wait");
    for (int i = 0; i < 16; i++) e[i] = dw(i + 32);
    chk("w16_a_blk", block_out, e);
    chk("w16_a_flags", {510'd0, block_first, block_final}, 512'd2);
    ack;
    wait_blk("w16_b_wait");
    e = '0; e[0] = 32'h8000_0000; e[15] = 32'h0000_0200;
    chk("w16_b_blk", block_out, e);
    chk("w16_b_flags", {510'd0, block_first, block_final}, 512'd1);
    ack;

    // 17 words: full data block with 1-cycle latency, then a short final block
    for (int i = 0; i < 16; i++) send(dw(i + 64), 1'b0, 2'd0);
    chk("w17_lat", {510'd0, block_valid, data_ready}, 512'd2);
    for (int i = 0; i < 16; i++) e[i] = dw(i + 64);
    chk("w17_a_blk", block_out, e);
    chk("w17_a_flags", {510'd0, block_first, block_final}, 512'd2);
    ack;
    send(32'h1234_5678, 1'b1, 2'd0);
    wait_blk("w17_b_wait");
    e = '0; e[0] = 32'h1234_5678; e[1] = 32'h8000_0000; e[15] = 32'h0000_0220;
    chk("w17_b_blk", block_out, e);
    chk("w17_b_flags", {510'd0, block_first, block_final}, 512'd1);
    ack;

    // 6-byte message: tail bytes of the last word are masked off
    send(32'h1122_3344, 1'b0, 2'd0);
    send(32'hAABB_CCDD, 1'b1, 2'd2);
    wait_blk("b6_wait");
    e = '0; e[0] = 32'h1122_3344; e[1] = 32'hAABB_8000; e[15] = 32'h0000_0030;
    chk("b6_blk", block_out, e);
    chk("b6_flags", {510'd0, block_first, block_final}, 512'd3);
    ack;

    // reset after 5 words aborts the message
    for (int i = 0; i < 5; i++) send(dw(i + 100), 1'b0, 2'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_out", block_out, 512'd0);
    RST = 1'b1;
    @(negedge CLK);
    run_abc("abc_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
